// File: rtl/msix_irq_ctrl.sv
// msix_irq_ctrl: multi-vector MSI-X interrupt controller.
// Decodes one-hot requests into a pending-bit array, applies function and
// per-vector masks, coalesces repeats and delivers pending vectors
// round-robin over a valid/ready channel with sent/fail feedback.
module msix_irq_ctrl #(
  parameter int NVEC = 32,
  parameter int DATW = 32,
  parameter int VECW = (NVEC > 1) ? $clog2(NVEC) : 1,
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            cfg_interrupt_msix_int,
  input  logic [DATW-1:0] cfg_interrupt_msix_data,
  output logic            cfg_interrupt_msix_sent,
  output logic            cfg_interrupt_msix_fail,
  output logic [3:0]      cfg_interrupt_msix_enable,
  output logic [3:0]      cfg_interrupt_msix_mask,
  input  logic            msix_en,
  input  logic            fn_mask,
  input  logic [NVEC-1:0] vec_mask,
  output logic            irq_valid,
  output logic [VECW-1:0] irq_vector,
  input  logic            irq_ready,
  output logic [NVEC-1:0] pending,
  output logic [CNTW-1:0] fail_cnt,
  output logic [CNTW-1:0] coal_cnt
);

  // Index width wide enough to hold any bit position of the data word and NVEC itself.
  localparam int IDXW  = $clog2(DATW) + 1;
  // Candidate width for the pointer+offset sum before wrapping.
  localparam int CANDW = VECW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [NVEC-1:0]  pending_r, pending_nxt_s, elig_s, clr_s, set_s;
  logic [VECW-1:0]  vec_r, ptr_r, ptr_nxt_s, grant_idx_s, req_vec_s;
  logic [IDXW-1:0]  req_idx_s;
  logic [CANDW-1:0] cand_s;
  logic [CNTW-1:0]  fail_cnt_r, coal_cnt_r;
  logic             valid_r, sent_r, fail_r;
  logic             req_ok_s, req_fail_s, req_coal_s, inflight_s;
  logic             grant_found_s, hit_s, do_grant_s, do_hshake_s;

  // True when exactly one bit of the request word is set.
  function automatic logic is_onehot(input logic [DATW-1:0] d);
    return (d != {DATW{1'b0}}) && ((d & (d - DATW'(1'b1))) == {DATW{1'b0}});
  endfunction

  // Position of the highest set bit (the only one for a one-hot word).
  function automatic logic [IDXW-1:0] onehot_idx(input logic [DATW-1:0] d);
    logic [IDXW-1:0] idx;
    idx = {IDXW{1'b0}};
    for (int i = 0; i < DATW; i++) begin
      idx = d[i] ? IDXW'(i) : idx;
    end
    return idx;
  endfunction

  // Classify the incoming request as rejected, new, or coalesced.
  always_comb begin
    req_idx_s  = onehot_idx(cfg_interrupt_msix_data);
    req_vec_s  = req_idx_s[VECW-1:0];
    req_ok_s   = 1'b0;
    req_fail_s = 1'b0;
    req_coal_s = 1'b0;
    if (cfg_interrupt_msix_int) begin
      if (msix_en && is_onehot(cfg_interrupt_msix_data) && (req_idx_s < IDXW'(NVEC))) begin
        req_ok_s   = 1'b1;
        req_coal_s = pending_r[req_vec_s] || (inflight_s && (req_vec_s == vec_r));
      end else begin
        req_fail_s = 1'b1;
      end
    end else begin
      req_ok_s = 1'b0;
    end
  end

  // Round-robin search for the first eligible vector at or above the pointer.
  always_comb begin
    elig_s        = pending_r & ~vec_mask & {NVEC{msix_en & ~fn_mask}};
    grant_found_s = 1'b0;
    grant_idx_s   = {VECW{1'b0}};
    cand_s        = {CANDW{1'b0}};
    hit_s         = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      cand_s        = {1'b0, ptr_r} + CANDW'(i);
      cand_s        = (cand_s >= CANDW'(NVEC)) ? (cand_s - CANDW'(NVEC)) : cand_s;
      hit_s         = elig_s[cand_s[VECW-1:0]] & ~grant_found_s;
      grant_idx_s   = hit_s ? cand_s[VECW-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: arbitrate, wait for the handshake, pulse sent.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = grant_found_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt_s = irq_ready ? ST_ACK : ST_ISSUE;
      ST_ACK:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: grant/handshake strobes and in-flight status.
  always_comb begin
    do_grant_s  = 1'b0;
    do_hshake_s = 1'b0;
    inflight_s  = 1'b0;
    case (state_r)
      ST_IDLE:  do_grant_s = grant_found_s;
      ST_ISSUE: begin
        do_hshake_s = irq_ready;
        inflight_s  = 1'b1;
      end
      ST_ACK:   inflight_s = 1'b1;
      default:  inflight_s = 1'b0;
    endcase
    ptr_nxt_s = (vec_r == VECW'(NVEC - 1)) ? {VECW{1'b0}} : (vec_r + VECW'(1'b1));
  end

  // Pending-bit update: granted vector cleared, new non-coalesced request set.
  always_comb begin
    clr_s         = do_grant_s ? (NVEC'(1'b1) << grant_idx_s) : {NVEC{1'b0}};
    set_s         = (req_ok_s && !req_coal_s) ? (NVEC'(1'b1) << req_vec_s) : {NVEC{1'b0}};
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
  end

  // Pending-bit array register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_r <= {NVEC{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Delivery channel: load vector on grant, drop valid and advance pointer on handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_r <= 1'b0;
      vec_r   <= {VECW{1'b0}};
      ptr_r   <= {VECW{1'b0}};
      sent_r  <= 1'b0;
    end else begin
      sent_r <= do_hshake_s;
      if (do_grant_s) begin
        valid_r <= 1'b1;
        vec_r   <= grant_idx_s;
      end else if (do_hshake_s) begin
        valid_r <= 1'b0;
        ptr_r   <= ptr_nxt_s;
      end
    end
  end

  // Fail pulse and saturating statistics counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fail_r     <= 1'b0;
      fail_cnt_r <= {CNTW{1'b0}};
      coal_cnt_r <= {CNTW{1'b0}};
    end else begin
      fail_r <= req_fail_s;
      if (req_fail_s && (fail_cnt_r != {CNTW{1'b1}})) begin
        fail_cnt_r <= fail_cnt_r + CNTW'(1'b1);
      end
      if (req_ok_s && req_coal_s && (coal_cnt_r != {CNTW{1'b1}})) begin
        coal_cnt_r <= coal_cnt_r + CNTW'(1'b1);
      end
    end
  end

  assign cfg_interrupt_msix_sent   = sent_r;
  assign cfg_interrupt_msix_fail   = fail_r;
  assign cfg_interrupt_msix_enable = {3'b000, msix_en};
  assign cfg_interrupt_msix_mask   = {3'b000, fn_mask};
  assign irq_valid                 = valid_r;
  assign irq_vector                = vec_r;
  assign pending                   = pending_r;
  assign fail_cnt                  = fail_cnt_r;
  assign coal_cnt                  = coal_cnt_r;

endmodule

// File: tb/tb_msix_irq_ctrl.sv
// Testbench for msix_irq_ctrl: directed scenarios plus randomized
// single-outstanding transactions checked against a transaction-level model.
module tb_msix_irq_ctrl;

  localparam int NVEC = 32;
  localparam int DATW = 32;
  localparam int VECW = 5;
  localparam int CNTW = 3;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            cfg_interrupt_msix_int = 1'b0;
  logic [DATW-1:0] cfg_interrupt_msix_data = '0;
  logic            cfg_interrupt_msix_sent;
  logic            cfg_interrupt_msix_fail;
  logic [3:0]      cfg_interrupt_msix_enable;
  logic [3:0]      cfg_interrupt_msix_mask;
  logic            msix_en = 1'b1;
  logic            fn_mask = 1'b0;
  logic [NVEC-1:0] vec_mask = '0;
  logic            irq_valid;
  logic [VECW-1:0] irq_vector;
  logic            irq_ready = 1'b1;
  logic [NVEC-1:0] pending;
  logic [CNTW-1:0] fail_cnt;
  logic [CNTW-1:0] coal_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  msix_irq_ctrl #(.NVEC(NVEC), .DATW(DATW), .CNTW(CNTW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .cfg_interrupt_msix_int(cfg_interrupt_msix_int),
    .cfg_interrupt_msix_data(cfg_interrupt_msix_data),
    .cfg_interrupt_msix_sent(cfg_interrupt_msix_sent),
    .cfg_interrupt_msix_fail(cfg_interrupt_msix_fail),
    .cfg_interrupt_msix_enable(cfg_interrupt_msix_enable),
    .cfg_interrupt_msix_mask(cfg_interrupt_msix_mask),
    .msix_en(msix_en), .fn_mask(fn_mask), .vec_mask(vec_mask),
    .irq_valid(irq_valid), .irq_vector(irq_vector), .irq_ready(irq_ready),
    .pending(pending), .fail_cnt(fail_cnt), .coal_cnt(coal_cnt)
  );

  // Rejection rule: disabled, zero, multi-hot or out-of-range index.
  function automatic bit exp_fail(input logic [DATW-1:0] d, input bit en);
    bit bad;
    bad = !en || ($countones(d) != 1);
    for (int i = NVEC; i < DATW; i++) if (d[i]) bad = 1'b1;
    return bad;
  endfunction

  // Saturating counter expectation.
  function automatic logic [CNTW-1:0] sat(input int n);
    int lim;
    lim = (1 << CNTW) - 1;
    return (n > lim) ? CNTW'(lim) : CNTW'(n);
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    cfg_interrupt_msix_int = 1'b0;
    cfg_interrupt_msix_data = '0;
    msix_en = 1'b1; fn_mask = 1'b0; vec_mask = '0; irq_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  // Drive a one-cycle request strobe; returns at the following negedge.
  task automatic strobe(input logic [DATW-1:0] d);
    cfg_interrupt_msix_int = 1'b1;
    cfg_interrupt_msix_data = d;
    @(negedge i_clk);
    cfg_interrupt_msix_int = 1'b0;
    cfg_interrupt_msix_data = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; msix_en = 1'b1; fn_mask = 1'b1;
    @(negedge i_clk);
    n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", irq_valid); end
    n_checks++; if (irq_vector !== 5'd0) begin n_fail++; $display("FAIL reset_vector: got %0d want 0", irq_vector); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_checks++; if ({cfg_interrupt_msix_sent, cfg_interrupt_msix_fail} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {cfg_interrupt_msix_sent, cfg_interrupt_msix_fail}); end
    n_checks++; if ({fail_cnt, coal_cnt} !== 6'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", fail_cnt, coal_cnt); end
    n_checks++; if ({cfg_interrupt_msix_enable, cfg_interrupt_msix_mask} !== 8'h11) begin n_fail++; $display("FAIL reset_en_mask: got %h want 11", {cfg_interrupt_msix_enable, cfg_interrupt_msix_mask}); end
    msix_en = 1'b0; fn_mask = 1'b0; #1;
    n_checks++; if ({cfg_interrupt_msix_enable, cfg_interrupt_msix_mask} !== 8'h00) begin n_fail++; $display("FAIL en_mask_low: got %h want 00", {cfg_interrupt_msix_enable, cfg_interrupt_msix_mask}); end
    do_reset();
  endtask

  task automatic test_single();
    int sent_seen;
    do_reset();
    strobe(32'h0000_0010);
    n_checks++; if (pending !== 32'h0000_0010) begin n_fail++; $display("FAIL single_pending: got %h want 00000010", pending); end
    @(negedge i_clk);
    n_checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd4) begin n_fail++; $display("FAIL single_issue: got valid=%b vec=%0d want 1/4", irq_valid, irq_vector); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL single_pend_clr: got %h want 0", pending); end
    @(negedge i_clk);
    n_checks++; if (cfg_interrupt_msix_sent !== 1'b1) begin n_fail++; $display("FAIL single_sent: got %b want 1", cfg_interrupt_msix_sent); end
    sent_seen = 0;
    repeat (6) begin @(negedge i_clk); sent_seen += int'(cfg_interrupt_msix_sent); end
    n_checks++; if (sent_seen != 0) begin n_fail++; $display("FAIL single_extra_sent: got %0d want 0", sent_seen); end
  endtask

  task automatic test_fail();
    logic [DATW-1:0] dat [3];
    bit en [3];
    int nf, valid_seen;
    bit f;
    dat = '{32'h0, 32'h3, 32'h1};
    en  = '{1'b1, 1'b1, 1'b0};
    do_reset();
    nf = 0; valid_seen = 0;
    for (int k = 0; k < 9; k++) begin
      msix_en = (k < 3) ? en[k] : 1'b1;
      f = (k < 3) ? exp_fail(dat[k], en[k]) : exp_fail(32'h0, 1'b1);
      strobe((k < 3) ? dat[k] : 32'h0);
      if (f) nf++;
      valid_seen += int'(irq_valid);
      n_checks++; if (cfg_interrupt_msix_fail !== f) begin n_fail++; $display("FAIL fail_pulse[%0d]: got %b want %b", k, cfg_interrupt_msix_fail, f); end
      n_checks++; if (fail_cnt !== sat(nf)) begin n_fail++; $display("FAIL fail_cnt[%0d]: got %0d want %0d", k, fail_cnt, sat(nf)); end
    end
    repeat (4) begin @(negedge i_clk); valid_seen += int'(irq_valid); end
    n_checks++; if (valid_seen != 0 || pending !== 32'h0) begin n_fail++; $display("FAIL fail_no_delivery: got valid_cycles=%0d pending=%h want 0/0", valid_seen, pending); end
  endtask

  task automatic test_mask();
    int valid_seen, sent_cnt, got_vec;
    do_reset();
    vec_mask = 32'h0000_0080;
    strobe(32'h0000_0080);
    valid_seen = 0;
    repeat (5) begin valid_seen += int'(irq_valid); @(negedge i_clk); end
    n_checks++; if (pending !== 32'h0000_0080 || valid_seen != 0) begin n_fail++; $display("FAIL mask_hold: got pending=%h valid_cycles=%0d want 00000080/0", pending, valid_seen); end
    vec_mask = '0;
    sent_cnt = 0; got_vec = -1;
    repeat (10) begin
      @(negedge i_clk);
      if (irq_valid) got_vec = int'(irq_vector);
      sent_cnt += int'(cfg_interrupt_msix_sent);
    end
    n_checks++; if (sent_cnt != 1 || got_vec != 7) begin n_fail++; $display("FAIL mask_release: got sent=%0d vec=%0d want 1/7", sent_cnt, got_vec); end
  endtask

  task automatic test_round_robin();
    logic [NVEC-1:0] pend_m;
    int last, sent_cnt;
    int exp_q[$];
    int got_q[$];
    do_reset();
    strobe(32'h1 << 5);
    sent_cnt = 0;
    repeat (5) begin @(negedge i_clk); sent_cnt += int'(cfg_interrupt_msix_sent); end
    n_checks++; if (sent_cnt != 1) begin n_fail++; $display("FAIL rr_first_sent: got %0d want 1", sent_cnt); end
    pend_m = (32'h1 << 2) | (32'h1 << 5) | (32'h1 << 30);
    vec_mask = pend_m;
    strobe(32'h1 << 2); strobe(32'h1 << 5); strobe(32'h1 << 30);
    n_checks++; if (pending !== pend_m) begin n_fail++; $display("FAIL rr_pending: got %h want %h", pending, pend_m); end
    last = 5;
    for (int k = 0; k < 3; k++) begin
      for (int off = 1; off <= NVEC; off++) begin
        int c;
        c = (last + off) % NVEC;
        if (pend_m[c]) begin exp_q.push_back(c); pend_m[c] = 1'b0; last = c; break; end
      end
    end
    vec_mask = '0; sent_cnt = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (irq_valid) got_q.push_back(int'(irq_vector));
      sent_cnt += int'(cfg_interrupt_msix_sent);
    end
    n_checks++; if (got_q.size() != 3 || sent_cnt != 3) begin n_fail++; $display("FAIL rr_count: got deliveries=%0d sent=%0d want 3/3", got_q.size(), sent_cnt); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] != exp_q[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_coalesce();
    int drop, sent_cnt, valid_cnt;
    do_reset();
    irq_ready = 1'b0;
    strobe(32'h8);
    @(negedge i_clk);
    n_checks++; if (irq_valid !== 1'b1 || irq_vector !== 5'd3) begin n_fail++; $display("FAIL coal_issue: got valid=%b vec=%0d want 1/3", irq_valid, irq_vector); end
    strobe(32'h8);
    drop = 0; sent_cnt = 0;
    repeat (10) begin
      if (irq_valid !== 1'b1 || irq_vector !== 5'd3) drop++;
      sent_cnt += int'(cfg_interrupt_msix_sent);
      @(negedge i_clk);
    end
    n_checks++; if (drop != 0 || sent_cnt != 0) begin n_fail++; $display("FAIL coal_hold: got drops=%0d sent=%0d want 0/0", drop, sent_cnt); end
    n_checks++; if (coal_cnt !== 3'd1 || pending !== 32'h0) begin n_fail++; $display("FAIL coal_cnt: got coal=%0d pending=%h want 1/0", coal_cnt, pending); end
    irq_ready = 1'b1; sent_cnt = 0; valid_cnt = 0;
    repeat (10) begin
      @(negedge i_clk);
      sent_cnt += int'(cfg_interrupt_msix_sent);
      valid_cnt += int'(irq_valid);
    end
    n_checks++; if (sent_cnt != 1 || valid_cnt != 0) begin n_fail++; $display("FAIL coal_single: got sent=%0d extra_valid=%0d want 1/0", sent_cnt, valid_cnt); end
  endtask

  task automatic test_reset_mid_issue();
    int act;
    do_reset();
    irq_ready = 1'b0;
    strobe(32'h0);
    strobe(32'h1 << 9);
    @(negedge i_clk);
    strobe(32'h1 << 11);
    n_checks++; if (irq_valid !== 1'b1 || fail_cnt !== 3'd1 || pending !== (32'h1 << 11)) begin n_fail++; $display("FAIL rst_pre: got valid=%b fail_cnt=%0d pending=%h want 1/1/00000800", irq_valid, fail_cnt, pending); end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++; if (irq_valid !== 1'b0 || pending !== 32'h0 || fail_cnt !== 3'd0 || coal_cnt !== 3'd0 || irq_vector !== 5'd0) begin n_fail++; $display("FAIL rst_async: got valid=%b pending=%h fail=%0d coal=%0d vec=%0d want all 0", irq_valid, pending, fail_cnt, coal_cnt, irq_vector); end
    @(negedge i_clk);
    i_rst_n = 1'b1; irq_ready = 1'b1; act = 0;
    repeat (10) begin @(negedge i_clk); act += int'(cfg_interrupt_msix_sent) + int'(irq_valid); end
    n_checks++; if (act != 0) begin n_fail++; $display("FAIL rst_no_sent: got activity=%0d want 0", act); end
  endtask

  task automatic test_random();
    logic [DATW-1:0] d;
    bit en, f, done;
    int idx, hold, kind, nf, sent_cnt, bad_vec, extra, c;
    do_reset();
    nf = 0;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      idx = $urandom_range(0, NVEC - 1);
      if (kind == 0) d = '0;
      else if (kind == 1) d = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
      else d = 32'h1 << idx;
      en = ($urandom_range(0, 9) != 0);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      msix_en = en;
      if (hold > 0) begin
        if ($urandom_range(0, 1) == 1) fn_mask = 1'b1;
        else vec_mask = d;
      end
      f = exp_fail(d, en);
      if (f) nf++;
      strobe(d);
      msix_en = 1'b1;
      n_checks++; if (cfg_interrupt_msix_fail !== f) begin n_fail++; $display("FAIL rand_fail_pulse[%0d]: got %b want %b data=%h en=%b", t, cfg_interrupt_msix_fail, f, d, en); end
      n_checks++; if (fail_cnt !== sat(nf)) begin n_fail++; $display("FAIL rand_fail_cnt[%0d]: got %0d want %0d", t, fail_cnt, sat(nf)); end
      sent_cnt = 0; bad_vec = 0; done = f; c = 0;
      while (!done && c < 60) begin
        if (c >= hold) begin fn_mask = 1'b0; vec_mask = '0; end
        irq_ready = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        if (irq_valid && irq_vector !== VECW'(idx)) bad_vec++;
        if (cfg_interrupt_msix_sent) begin sent_cnt++; done = 1'b1; end
        c++;
      end
      fn_mask = 1'b0; vec_mask = '0; irq_ready = 1'b1;
      n_checks++; if (sent_cnt != (f ? 0 : 1) || bad_vec != 0) begin n_fail++; $display("FAIL rand_delivery[%0d]: got sent=%0d bad_vec=%0d want %0d/0 (idx %0d)", t, sent_cnt, bad_vec, f ? 0 : 1, idx); end
      extra = 0;
      repeat (3) begin
        @(negedge i_clk);
        extra += int'(cfg_interrupt_msix_sent) + int'(cfg_interrupt_msix_fail) + int'(irq_valid);
      end
      n_checks++; if (extra != 0 || pending !== 32'h0 || coal_cnt !== 3'd0) begin n_fail++; $display("FAIL rand_quiet[%0d]: got extra=%0d pending=%h coal=%0d want 0/0/0", t, extra, pending, coal_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fail();
    test_mask();
    test_round_robin();
    test_coalesce();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msix_irq_ctrl.md
Name: msix_irq_ctrl

Overview:
- Parametrised successor to the single-shot MSI-X interrupt shim: a multi-vector MSI-X interrupt controller between the user-logic MSI-X request interface and the host-side DPI interrupt channel.
- Decodes one-hot interrupt requests and keeps per-vector pending bits.
- Honours per-vector and function masks, and coalesces repeated requests.
- Arbitrates pending vectors round-robin onto a valid/ready delivery handshake, and returns sent/fail pulses to the requester.

Parameters:
- NVEC, 32, number of MSI-X vectors, 1..DATW.
- DATW, 32, width of cfg_interrupt_msix_data (one-hot field).
- VECW, $clog2(NVEC) (min 1), width of the binary vector index.
- CNTW, 16, width of the fail/coalesce statistics counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- cfg_interrupt_msix_int  in  1  request strobe, single-cycle pulse
- cfg_interrupt_msix_data  in  DATW  one-hot vector select, sampled with the strobe
- cfg_interrupt_msix_sent  out  1  one-cycle pulse: one request's vector delivered to host
- cfg_interrupt_msix_fail  out  1  one-cycle pulse: request rejected
- cfg_interrupt_msix_enable  out  4  {3'b0, msix_en}
- cfg_interrupt_msix_mask  out  4  {3'b0, fn_mask}
- msix_en  in  1  host MSI-X enable
- fn_mask  in  1  host function mask
- vec_mask  in  NVEC  host per-vector mask, 1 = masked
- irq_valid  out  1  delivery request to host channel
- irq_vector  out  VECW  binary vector index, stable while irq_valid
- irq_ready  in  1  host accepts delivery
- pending  out  NVEC  pending-bit array (PBA) view
- fail_cnt  out  CNTW  saturating count of fail pulses
- coal_cnt  out  CNTW  saturating count of coalesced requests

Behaviour:
- Reset (async assert, synchronous-to-i_clk deassert is the integrator's job): pending=0, irq_valid=0, irq_vector=0, sent=0, fail=0, fail_cnt=0, coal_cnt=0, round-robin pointer=0, state IDLE.
- Request decode, in the cycle the strobe is high:
  - data zero, multi-hot, set bit index >= NVEC, or msix_en=0 -> fail pulse next cycle, fail_cnt++.
  - Otherwise set pending[idx].
  - If pending[idx] is already 1, or idx is the vector currently in flight, count it in coal_cnt++; no second delivery and no second sent pulse.
- Every non-failed request produces exactly one sent pulse: at the handshake of the delivery that services it. A coalesced request shares that sent pulse; requester must hold off new requests until sent/fail.
- Eligibility: eligible = pending & ~vec_mask, all bits gated by msix_en & ~fn_mask. Masked vectors stay pending indefinitely and deliver once unmasked.
- FSM:
  - IDLE: if eligible != 0, choose the first set bit searching upward from ptr, wrapping at NVEC-1 -> 0. Load irq_vector, clear that pending bit, go to ISSUE. irq_valid=1 the next cycle (1-cycle eligible-to-valid latency).
  - ISSUE: hold irq_valid and irq_vector until irq_ready=1. On the handshake cycle go to ACK and set ptr = irq_vector+1 (wrap).
  - ACK: sent pulse (exactly one cycle), irq_valid=0, return to IDLE. Minimum spacing between deliveries is 3 cycles.
- Valid is never retracted: mask, fn_mask or msix_en changes during ISSUE do not drop the in-flight vector.
- Simultaneous new request for the in-flight vector during ISSUE/ACK: that request is coalesced into the in-flight delivery; pending is not re-set.
- Simultaneous request for another vector and the arbitration decision: the new bit is set and competes next IDLE.
- sent and fail may pulse in the same cycle (different requests).
- Counters saturate at all-ones.
- Reset mid-ISSUE: irq_valid drops immediately (async); no sent pulse is issued.

Test Plan:
- msix_en=1, masks 0, strobe data=32'h0000_0010 -> pending[4] set, then cleared with irq_valid=1, irq_vector=4. With irq_ready high, sent pulses exactly once, 3 cycles after the strobe.
- Strobe data=0, then data=32'h0000_0003, then msix_en=0 with data=1 -> three fail pulses, fail_cnt=3, irq_valid never asserts.
- vec_mask[7]=1, request vector 7 -> pending[7]=1, no delivery. Clear vec_mask[7] -> delivery of vector 7, one sent pulse.
- Pend vectors 2, 5, 30 (all masked), last delivered = 5, then unmask all -> delivery order 30, 2, 5 (round-robin wrap).
- Request vector 3 while vector 3 is in ISSUE with irq_ready=0 for 10 cycles -> coal_cnt=1, a single delivery, a single sent pulse.
- Assert i_rst_n=0 during ISSUE -> irq_valid, pending, and counters all 0 in the same cycle; no sent pulse after release.
